counter_link_engine: RTL and testbench

Protocol end for the dual-latch timestamp counter. Reads each latched counter register and serialises it to the host byte stream as a tag byte (00 or 01) followed by the counter bytes. Decodes host command bytes into release strobes (oResetLatch1/2) and test-trigger pulses (oLatch1/2). Sits between the counter block and the USB/UART byte FIFO.

---
 rtl/counter_link_engine_pkg.sv | 9 +
 rtl/counter_link_engine_if.sv | 10 +
 rtl/counter_link_engine_pulse_stretch.sv | 17 +
 rtl/counter_link_engine.sv | 97 +++++++++
 tb/tb_counter_link_engine.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_link_engine_pkg.sv
// counter_link_pkg: FSM states and host byte codes shared by the counter link engine.
package counter_link_pkg;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, RELEASE} stateT;
    localparam logic [7:0] TAG1 = 8'h00, ACK1 = 8'h00, TAG2 = 8'h01, ACK2 = 8'h01;
    localparam logic [7:0] CMD_TRIG1 = 8'h02, CMD_TRIG2 = 8'h03;
    function automatic logic [7:0] chTag(input logic ch);
        return ch ? TAG2 : TAG1;
    endfunction
endpackage

// File: rtl/counter_link_engine_if.sv
// counter_link_engine_if: host byte stream, tx towards the FIFO and rx strobes from the host.
interface counter_link_engine_if;
    logic [7:0] oTxData;
    logic       oTxValid;
    logic       iTxReady;
    logic [7:0] iRxData;
    logic       iRxValid;
    modport master (output oTxData, oTxValid, input iTxReady, iRxData, iRxValid);
    modport slave  (input oTxData, oTxValid, output iTxReady, iRxData, iRxValid);
endinterface

// File: rtl/counter_link_engine_pulse_stretch.sv
// pulse_stretch: holds oPulse high for pPULSE_LEN cycles after iTrig; a retrigger restarts the count.
module pulse_stretch #(
    parameter int pPULSE_LEN = 4
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iTrig,
    output logic oPulse
);
    localparam int CW = $clog2(pPULSE_LEN + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) cnt <= '0;
        else if (iTrig) cnt <= CW'(pPULSE_LEN);
        else if (cnt != '0) cnt <= cnt - CW'(1);
    assign oPulse = cnt != '0;
endmodule

// File: rtl/counter_link_engine.sv
// counter_link_engine: serialises latched counter registers to the host as tag + MSB-first bytes,
// waits for the host ack and releases the register; also decodes host test-trigger commands.
module counter_link_engine
    import counter_link_pkg::*;
#(
    parameter int pWIDTH       = 40,
    parameter int pACK_TIMEOUT = 1000000,
    parameter int pPULSE_LEN   = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [31:0]       i1COUNTER,
    input  logic [pWIDTH-33:0] i1COUNTERHi,
    input  logic              iRdy1,
    input  logic [31:0]       i2COUNTER,
    input  logic [pWIDTH-33:0] i2COUNTERHi,
    input  logic              iRdy2,
    output logic              oResetLatch1,
    output logic              oResetLatch2,
    output logic              oLatch1,
    output logic              oLatch2,
    counter_link_engine_if.master host,
    output logic              oBusy,
    output logic [7:0]        oBadCmd
);
    localparam int NBYTES = pWIDTH / 8;
    localparam int IW = $clog2(NBYTES + 1);
    localparam int TW = $clog2(pACK_TIMEOUT + 1);

    stateT state, nextState;
    logic rdyQ1, rdyQ2, ptr, ch, serve, serveCh, rdySel;
    logic accept, lastByte, ackOk, timeout, rxTrig1, rxTrig2, rxBad;
    logic [pWIDTH-1:0] shadow;
    logic [IW-1:0] idx;
    logic [TW-1:0] timer;

    // ptr names the preferred channel (0 = ch1); the other channel is served only when it is idle
    assign serve    = rdyQ1 | rdyQ2;
    assign serveCh  = (ptr ? rdyQ2 : rdyQ1) ? ptr : ~ptr;
    assign rdySel   = ch ? rdyQ2 : rdyQ1;
    assign accept   = state == SEND && host.iTxReady;
    assign lastByte = idx == IW'(NBYTES);
    assign ackOk    = state == WAIT_ACK && host.iRxValid && host.iRxData == chTag(ch);
    assign timeout  = timer == TW'(pACK_TIMEOUT - 1);
    assign rxTrig1  = host.iRxValid && host.iRxData == CMD_TRIG1;
    assign rxTrig2  = host.iRxValid && host.iRxData == CMD_TRIG2;
    assign rxBad    = host.iRxValid && (host.iRxData > CMD_TRIG2 || (host.iRxData <= ACK2 && !ackOk));

    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) state <= IDLE;
        else state <= nextState;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (serve) nextState = SEND;
            SEND:     if (accept && lastByte) nextState = WAIT_ACK;
            WAIT_ACK: if (ackOk) nextState = RELEASE; else if (timeout) nextState = SEND;
            RELEASE:  if (!rdySel) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) begin
            rdyQ1   <= 1'b0;
            rdyQ2   <= 1'b0;
            ptr     <= 1'b0;
            ch      <= 1'b0;
            shadow  <= '0;
            idx     <= '0;
            timer   <= '0;
            oBadCmd <= '0;
        end else begin
            rdyQ1 <= iRdy1;
            rdyQ2 <= iRdy2;
            if (state == IDLE && serve) begin
                ch     <= serveCh;
                ptr    <= ~serveCh;
                shadow <= serveCh ? {i2COUNTERHi, i2COUNTER} : {i1COUNTERHi, i1COUNTER};
            end
            idx     <= state != SEND ? '0 : accept ? idx + IW'(1) : idx;
            timer   <= state == WAIT_ACK ? timer + TW'(1) : '0;
            oBadCmd <= rxBad && oBadCmd != 8'hFF ? oBadCmd + 8'd1 : oBadCmd;
        end

    always_comb begin
        host.oTxValid = state == SEND;
        host.oTxData  = state != SEND ? 8'h00 : idx == '0 ? chTag(ch) : 8'(shadow >> (8 * (NBYTES - int'(idx))));
        oResetLatch1  = state == RELEASE && !ch;
        oResetLatch2  = state == RELEASE && ch;
        oBusy         = state != IDLE;
    end

    pulse_stretch #(.pPULSE_LEN(pPULSE_LEN)) uPulse1 (.iCLK(iCLK), .iRST_N(iRST_N), .iTrig(rxTrig1), .oPulse(oLatch1));
    pulse_stretch #(.pPULSE_LEN(pPULSE_LEN)) uPulse2 (.iCLK(iCLK), .iRST_N(iRST_N), .iTrig(rxTrig2), .oPulse(oLatch2));
endmodule

// File: tb/tb_counter_link_engine.sv
// tb_counter_link_engine: randomized bench with a packet-level host/arbiter model for counter_link_engine.
module tb_counter_link_engine;
    localparam int NB = 5;
    localparam int TO = 16;

    logic iCLK = 1'b0;
    logic iRST_N = 1'b0;
    logic [39:0] val1 = '0, val2 = '0;
    logic iRdy1 = 1'b0, iRdy2 = 1'b0;
    logic oResetLatch1, oResetLatch2, oLatch1, oLatch2, oBusy;
    logic [7:0] oBadCmd;
    int checks = 0, failures = 0;
    int expBad = 0, ptrModel = 1;
    int lat1Cnt = 0, lat2Cnt = 0;
    logic [3:0] bpPat = 4'b1001;

    counter_link_engine_if host ();

    counter_link_engine #(.pWIDTH(40), .pACK_TIMEOUT(TO), .pPULSE_LEN(4)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .i1COUNTER(val1[31:0]), .i1COUNTERHi(val1[39:32]), .iRdy1(iRdy1),
        .i2COUNTER(val2[31:0]), .i2COUNTERHi(val2[39:32]), .iRdy2(iRdy2),
        .oResetLatch1(oResetLatch1), .oResetLatch2(oResetLatch2),
        .oLatch1(oLatch1), .oLatch2(oLatch2),
        .host(host), .oBusy(oBusy), .oBadCmd(oBadCmd)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK)
        if (iRST_N) begin
            lat1Cnt <= lat1Cnt + int'(oLatch1);
            lat2Cnt <= lat2Cnt + int'(oLatch2);
        end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // byte k of a packet: k=0 is the tag, then counter bytes most significant first
    function automatic logic [7:0] expByte(input int c, input logic [39:0] v, input int k);
        logic [63:0] d;
        d = 64'd1 << (8 * (NB - k));
        return k == 0 ? 8'(c - 1) : 8'((64'(v) / d) % 64'd256);
    endfunction

    function automatic int pick();
        int c;
        c = (iRdy1 && iRdy2) ? ptrModel : iRdy1 ? 1 : 2;
        ptrModel = 3 - c;
        return c;
    endfunction

    task automatic getPacket(input int c, input logic [39:0] v, input int bpMode, input int nBytes, input int expWait);
        int k, waits, ph;
        bit started;
        k = 0; waits = 0; ph = 0; started = 0;
        while (k < nBytes) begin
            @(negedge iCLK);
            host.iTxReady = bpMode == 0 ? 1'b1 : bpMode == 1 ? bpPat[ph % 4] : 1'($urandom_range(0, 1));
            ph++;
            if (!started) begin
                waits++;
                if (host.oTxValid) begin
                    started = 1;
                    if (expWait > 0) checkVal("latency", 64'(waits), 64'(expWait));
                end else if (waits > 200) begin
                    checkVal("txStart", 64'(host.oTxValid), 64'd1);
                    return;
                end
            end
            if (started) begin
                checkVal($sformatf("ch%0d_byte%0d", c, k), {host.oTxValid, host.oTxData}, {1'b1, expByte(c, v, k)});
                if (host.iTxReady) k++;
            end
        end
        if (nBytes == NB + 1) begin
            @(negedge iCLK);
            checkVal("txEnd", 64'(host.oTxValid), 64'd0);
        end
    endtask

    task automatic sendRx(input logic [7:0] b, input int waitCh);
        @(negedge iCLK);
        host.iRxData = b;
        host.iRxValid = 1'b1;
        if (b > 8'd3 || (b <= 8'd1 && int'(b) != waitCh - 1)) expBad = expBad < 255 ? expBad + 1 : 255;
        @(negedge iCLK);
        host.iRxValid = 1'b0;
    endtask

    task automatic ackRelease(input int c, input bit rearm, input logic [39:0] newV);
        logic [1:0] expL;
        expL = c == 1 ? 2'b01 : 2'b10;
        sendRx(8'(c - 1), c);
        checkVal("relSet", {oResetLatch2, oResetLatch1}, 64'(expL));
        if (c == 1) iRdy1 = 1'b0; else iRdy2 = 1'b0;
        @(negedge iCLK);
        checkVal("relHold", {oResetLatch2, oResetLatch1}, 64'(expL));
        if (rearm) begin
            if (c == 1) begin val1 = newV; iRdy1 = 1'b1; end
            else begin val2 = newV; iRdy2 = 1'b1; end
        end
        @(negedge iCLK);
        checkVal("relDrop", {oResetLatch2, oResetLatch1}, 64'd0);
    endtask

    task automatic doReset();
        @(negedge iCLK);
        iRST_N = 1'b0;
        expBad = 0;
        ptrModel = 1;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
    endtask

    function automatic logic [7:0] junkByte(input int c);
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 3);
        b = 8'($urandom_range(0, 255));
        if (b == 8'(c - 1)) b = 8'hFF;
        return r == 0 ? 8'(2 - c) : r == 1 ? 8'($urandom_range(4, 255)) : r == 2 ? 8'($urandom_range(2, 3)) : b;
    endfunction

    initial begin
        int c, mask, l1, l2;
        logic [39:0] v;
        host.iTxReady = 1'b1;
        host.iRxValid = 1'b0;
        host.iRxData = 8'h00;
        repeat (2) @(negedge iCLK);
        checkVal("rstOut", {host.oTxValid, host.oTxData, oBusy, oBadCmd, oResetLatch1, oResetLatch2, oLatch1, oLatch2}, 64'd0);
        iRST_N = 1'b1;

        // channel 1 packet and release
        @(negedge iCLK);
        val1 = 40'h12_3456_789A;
        iRdy1 = 1'b1;
        c = pick();
        getPacket(c, val1, 0, NB + 1, 2);
        ackRelease(c, 1'b0, '0);
        checkVal("idleBusy", 64'(oBusy), 64'd0);

        // backpressure 1,0,0,1
        @(negedge iCLK);
        iRdy1 = 1'b1;
        c = pick();
        getPacket(c, val1, 1, NB + 1, 2);
        ackRelease(c, 1'b0, '0);

        // tie after reset, then a second tie while ch2 is preferred
        doReset();
        val1 = {$urandom, $urandom}; val2 = {$urandom, $urandom};
        iRdy1 = 1'b1; iRdy2 = 1'b1;
        c = pick();
        getPacket(c, val1, 0, NB + 1, 2);
        ackRelease(c, 1'b1, {$urandom, $urandom});
        c = pick();
        getPacket(c, val2, 2, NB + 1, 1);
        ackRelease(c, 1'b0, '0);
        c = pick();
        getPacket(c, val1, 2, NB + 1, 1);
        ackRelease(c, 1'b0, '0);

        // ack timeout: identical resend after TO idle cycles, then late ack
        @(negedge iCLK);
        val1 = {$urandom, $urandom};
        iRdy1 = 1'b1;
        c = pick();
        getPacket(c, val1, 0, NB + 1, 2);
        getPacket(c, val1, 0, NB + 1, TO);
        ackRelease(c, 1'b0, '0);

        // commands while waiting for the ch1 ack
        @(negedge iCLK);
        iRdy1 = 1'b1;
        c = pick();
        getPacket(c, val1, 0, NB + 1, 2);
        l1 = lat1Cnt; l2 = lat2Cnt;
        sendRx(8'h02, 1);
        sendRx(8'h03, 1);
        sendRx(8'h07, 1);
        sendRx(8'h01, 1);
        checkVal("lat1Len", 64'(lat1Cnt - l1), 64'd4);
        checkVal("lat2Len", 64'(lat2Cnt - l2), 64'd4);
        checkVal("badCmd", 64'(oBadCmd), 64'(expBad));
        checkVal("waitAck", {oBusy, host.oTxValid, oResetLatch1}, 64'b100);
        ackRelease(c, 1'b0, '0);

        // retrigger extends the pulse
        l1 = lat1Cnt;
        sendRx(8'h02, 0);
        sendRx(8'h02, 0);
        repeat (6) @(negedge iCLK);
        checkVal("lat1Restart", 64'(lat1Cnt - l1), 64'd6);

        // reset in the middle of a packet
        @(negedge iCLK);
        val1 = {$urandom, $urandom};
        iRdy1 = 1'b1;
        c = pick();
        getPacket(c, val1, 0, 3, 2);
        @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        checkVal("rstValid", 64'(host.oTxValid), 64'd0);
        expBad = 0;
        ptrModel = 1;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        checkVal("rstBad", 64'(oBadCmd), 64'(expBad));
        c = pick();
        getPacket(c, val1, 0, NB + 1, 2);
        ackRelease(c, 1'b0, '0);

        // randomized traffic
        repeat (10) begin
            mask = $urandom_range(1, 3);
            @(negedge iCLK);
            val1 = {$urandom, $urandom}; val2 = {$urandom, $urandom};
            iRdy1 = mask[0]; iRdy2 = mask[1];
            for (int i = 0; i < (mask == 3 ? 2 : 1); i++) begin
                c = pick();
                v = c == 1 ? val1 : val2;
                getPacket(c, v, 2, NB + 1, i == 0 ? 2 : 1);
                repeat ($urandom_range(0, 3)) sendRx(junkByte(c), c);
                ackRelease(c, 1'b0, '0);
            end
            checkVal("rndBad", 64'(oBadCmd), 64'(expBad));
            checkVal("rndIdle", 64'(oBusy), 64'd0);
        end

        repeat (260) sendRx(8'hAA, 0);
        checkVal("badSat", 64'(oBadCmd), 64'(expBad));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
